// File: rtl/btn_sel_arbiter.sv
// Four-button synchroniser/debouncer feeding a locked one-hot select arbiter.
// Optional BTN_ROUND_ROBIN_EN rotates the IDLE search start; the default build uses fixed priority with bit 0 highest.
module btn_sel_arbiter #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    output logic [3:0] sel,
    output logic [1:0] owner,
    output logic       sel_valid,
    output logic       sel_change
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;
    localparam logic [1:0] ST_GAP   = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       deb_q;
    logic [3:0]       deb_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [3:0]       sel_q;
    logic [3:0]       sel_d;
    logic [1:0]       owner_q;
    logic [1:0]       owner_d;
    logic             sel_valid_q;
    logic             sel_change_q;

    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             found;

`ifdef BTN_ROUND_ROBIN_EN
    logic [1:0]       last_q;
    logic [1:0]       last_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Any cycle where the synchronised level matches the accepted level restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
`ifdef BTN_ROUND_ROBIN_EN
            idx = last_q + 2'd1 + k[1:0];
`else
            idx = k[1:0];
`endif
            if (!found && deb_q[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        owner_d = owner_q;
`ifdef BTN_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (deb_q != 4'b0000) begin
                    owner_d = winner;
                    sel_d   = 4'b0001 << winner;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                sel_d = 4'b0001 << owner_q;
                if (!deb_q[owner_q]) begin
                    sel_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                sel_d   = '0;
`ifdef BTN_ROUND_ROBIN_EN
                last_d  = owner_q;
`endif
                state_d = ST_IDLE;
            end
            default: begin
                sel_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            owner_q      <= '0;
            sel_valid_q  <= 1'b0;
            sel_change_q <= 1'b0;
`ifdef BTN_ROUND_ROBIN_EN
            last_q       <= 2'd3;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            owner_q      <= owner_d;
            sel_valid_q  <= |sel_d;
            sel_change_q <= (sel_d != sel_q);
`ifdef BTN_ROUND_ROBIN_EN
            last_q       <= last_d;
`endif
        end
    end

    assign sel        = sel_q;
    assign owner      = owner_q;
    assign sel_valid  = sel_valid_q;
    assign sel_change = sel_change_q;

endmodule

// File: tb/tb_btn_sel_arbiter.sv
// Bench for btn_sel_arbiter: directed scenarios plus random button traffic against a sample-history model.
module tb_btn_sel_arbiter;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] sel;
    logic [1:0] owner;
    logic       sel_valid;
    logic       sel_change;

    btn_sel_arbiter #(
        .DEB_CYCLES(DEB),
        .CNT_W     (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .sel       (sel),
        .owner     (owner),
        .sel_valid (sel_valid),
        .sel_change(sel_change)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    // Reference: raw samples per edge, accepted levels, and who holds the select.
    logic [3:0] samples[$];
    logic [3:0] shist[$];
    logic [3:0] deb_m;
    int         holder;
    int         cool;
    int         last_m;
    logic [3:0] sel_m;
    logic       chg_m;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] d);
        int start;
`ifdef BTN_ROUND_ROBIN_EN
        start = (last_m + 1) % 4;
`else
        start = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (d[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        samples.delete();
        shist.delete();
        deb_m  = '0;
        holder = -1;
        cool   = 0;
        last_m = 3;
        sel_m  = '0;
        chg_m  = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] s_pre;
        logic [3:0] deb_old;
        logic [3:0] prev_sel;
        logic [3:0] v;
        bit         all_diff;
        samples.push_back(btn);
        if (samples.size() > 8) void'(samples.pop_front());
        // The synchronised level lags the pin by two samples.
        s_pre    = (samples.size() >= 3) ? samples[samples.size() - 3] : 4'b0000;
        deb_old  = deb_m;
        prev_sel = sel_m;
        if (holder >= 0) begin
            if (!deb_old[holder]) begin
                last_m = holder;
                holder = -1;
                cool   = 1;
            end
        end else if (cool > 0) begin
            cool--;
        end else if (deb_old != 4'b0000) begin
            holder = pick(deb_old);
        end
        sel_m = (holder >= 0) ? 4'(1 << holder) : 4'b0000;
        chg_m = (sel_m != prev_sel);
        // A level is accepted after DEB consecutive samples that disagree with it.
        shist.push_back(s_pre);
        if (shist.size() > DEB) void'(shist.pop_front());
        if (shist.size() == DEB) begin
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    v = shist[j];
                    if (v[i] == deb_old[i]) all_diff = 1'b0;
                end
                if (all_diff) deb_m[i] = ~deb_old[i];
            end
        end
    endtask

    task automatic tick(input logic [3:0] b);
        btn = b;
        @(posedge clk);
        model_step();
        #1;
        chk_eq("sel", 32'(sel), 32'(sel_m));
        chk_eq("sel_valid", 32'(sel_valid), 32'(|sel_m));
        chk_eq("sel_change", 32'(sel_change), 32'(chg_m));
        if (sel_m != 4'b0000) chk_eq("owner", 32'(owner), 32'(holder));
        if (sel_change === 1'b1) pulse_cnt++;
    endtask

    task automatic ticks(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) tick(b);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_rr;
        rst_n = 1'b0;
        btn   = '0;
        model_reset();
        #1;
        chk_eq("rst_sel", 32'(sel), 32'h0);
        chk_eq("rst_sel_valid", 32'(sel_valid), 32'h0);
        chk_eq("rst_sel_change", 32'(sel_change), 32'h0);
        chk_eq("rst_owner", 32'(owner), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Glitch shorter than the debounce window.
        pulse_cnt = 0;
        ticks(4'b0010, 3);
        ticks(4'b0000, 10);
        chk_eq("glitch_sel", 32'(sel), 32'h0);
        chk_eq("glitch_pulses", 32'(pulse_cnt), 32'h0);

        // Single press: grant appears on the 7th sampled edge.
        ticks(4'b0100, 6);
        chk_eq("press_early", 32'(sel), 32'h0);
        tick(4'b0100);
        chk_eq("press_sel", 32'(sel), 32'h4);
        chk_eq("press_owner", 32'(owner), 32'h2);
        chk_eq("press_valid", 32'(sel_valid), 32'h1);
        chk_eq("press_chg", 32'(sel_change), 32'h1);
        tick(4'b0100);
        chk_eq("press_chg_drop", 32'(sel_change), 32'h0);
        ticks(4'b0000, 12);

        // Lock and handover.
        ticks(4'b1010, 8);
        chk_eq("lock_sel", 32'(sel), 32'h2);
        ticks(4'b1011, 8);
        chk_eq("lock_hold", 32'(sel), 32'h2);
`ifdef BTN_ROUND_ROBIN_EN
        exp_rr = 4'b1000;
`else
        exp_rr = 4'b0001;
`endif
        ticks(4'b1001, 10);
        chk_eq("handover_sel", 32'(sel), 32'(exp_rr));
        ticks(4'b0000, 12);

        // Priority after owner 0 releases.
        ticks(4'b0001, 8);
        chk_eq("rr_prep", 32'(sel), 32'h1);
        ticks(4'b0000, 12);
        ticks(4'b1001, 8);
        chk_eq("rr_sel", 32'(sel), 32'(exp_rr));
        ticks(4'b0000, 12);

        // Bounce then hold.
        pulse_cnt = 0;
        for (int r = 0; r < 5; r++) begin
            ticks(4'b0100, 2);
            ticks(4'b0000, 2);
        end
        ticks(4'b0100, 6);
        chk_eq("bounce_early", 32'(sel), 32'h0);
        tick(4'b0100);
        chk_eq("bounce_sel", 32'(sel), 32'h4);
        ticks(4'b0100, 4);
        chk_eq("bounce_pulses", 32'(pulse_cnt), 32'h1);

        // Reset mid-grant clears without a clock edge.
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_eq("async_sel", 32'(sel), 32'h0);
        chk_eq("async_valid", 32'(sel_valid), 32'h0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        ticks(4'b0100, 6);
        chk_eq("rst_regrant_early", 32'(sel), 32'h0);
        tick(4'b0100);
        chk_eq("rst_regrant", 32'(sel), 32'h4);
        ticks(4'b0000, 12);

        // Random traffic.
        for (int seg = 0; seg < 120; seg++) begin
            ticks(4'($urandom_range(0, 15)), $urandom_range(1, 14));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
